// File: rtl/input_port_ctrl.sv
// input_port_ctrl: wormhole packet controller between a router input FIFO and the crossbar.
// Latency: FIFO non-empty -> o_req next cycle; first flit moves the cycle after the grant is seen.
// Backpressure: a flit moves only when FIFO non-empty, i_ready and i_grant; otherwise all state holds.
// Optional feature macro NOC_PKT_COUNT_EN adds the 16-bit forwarded-packet counter o_pkt_count.

`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 8
`endif

module input_port_ctrl #(
   parameter int                 WIDTH   = `TAM_FLIT,
   parameter int                 DEPTH   = `TAM_BUFFER,
   parameter logic [WIDTH/4-1:0] LOCAL_X = '0,
   parameter logic [WIDTH/4-1:0] LOCAL_Y = '0
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [WIDTH-1:0]       i_head,
   input  logic [$clog2(DEPTH):0] i_counter,
   output logic                   o_pull,
   output logic                   o_req,
   output logic [4:0]             o_port,
   input  logic                   i_grant,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_valid,
   input  logic                   i_ready
`ifdef NOC_PKT_COUNT_EN
   ,
   output logic [15:0]            o_pkt_count
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;
   typedef enum logic [1:0] {F_HDR, F_SIZE, F_PAY} flit_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t             state;
   flit_t              flit_idx;
   logic [WIDTH-1:0]   remaining;
   logic [WIDTH/4-1:0] dx;
   logic [WIDTH/4-1:0] dy;
   logic [4:0]         route;
   logic               fifo_nempty;
   logic               last;

   assign dx          = i_head[WIDTH/2-1:WIDTH/4];
   assign dy          = i_head[WIDTH/4-1:0];
   assign fifo_nempty = (i_counter != '0);

   // XY routing: resolve X first, then Y; equal coordinates mean the local port
   always_comb begin
      route = 5'b10000;
      if (dx > LOCAL_X)      route = 5'b00001;
      else if (dx < LOCAL_X) route = 5'b00010;
      else if (dy > LOCAL_Y) route = 5'b00100;
      else if (dy < LOCAL_Y) route = 5'b01000;
   end

   // Crossbar handshake and FIFO pop; data is the FIFO head passed straight through
   assign o_data  = i_head;
   assign o_valid = (state == SEND) && fifo_nempty;
   assign o_pull  = o_valid && i_ready && i_grant;

   // Last flit: a zero size flit ends the packet, otherwise the payload flit seen with one remaining
   assign last = ((flit_idx == F_SIZE) && (i_head == '0)) ||
                 ((flit_idx == F_PAY) && (remaining == ONE));

   // Request/stream FSM: request held from header detection until the last flit is transferred
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state     <= IDLE;
         o_req     <= 1'b0;
         o_port    <= '0;
         flit_idx  <= F_HDR;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_nempty) begin
                  o_port   <= route;
                  o_req    <= 1'b1;
                  flit_idx <= F_HDR;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (i_grant) state <= SEND;
            end
            SEND: begin
               if (o_pull) begin
                  case (flit_idx)
                     F_HDR:   flit_idx <= F_SIZE;
                     F_SIZE: begin
                        remaining <= i_head;
                        flit_idx  <= F_PAY;
                     end
                     F_PAY:   remaining <= remaining - ONE;
                     default: flit_idx <= F_HDR;
                  endcase
                  if (last) begin
                     state     <= IDLE;
                     o_req     <= 1'b0;
                     o_port    <= '0;
                     flit_idx  <= F_HDR;
                     remaining <= '0;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               o_req  <= 1'b0;
               o_port <= '0;
            end
         endcase
      end
   end

`ifdef NOC_PKT_COUNT_EN
   // Forwarded-packet counter, bumped on each last-flit transfer, wraps at 16 bits
   always_ff @(posedge i_clk) begin
      if (!i_rst)              o_pkt_count <= '0;
      else if (o_pull && last) o_pkt_count <= o_pkt_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// tb_input_port_ctrl: directed and randomized checks of input_port_ctrl against a packet-level model.
// The FIFO is a queue in the bench; the arbiter grants after a configurable delay.
// Outputs are sampled 1 time unit after the falling edge, inputs driven on the falling edge.

module tb_input_port_ctrl;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int LX    = 1;
   localparam int LY    = 1;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic [WIDTH-1:0] i_head;
   logic [CW-1:0]    i_counter;
   logic             o_pull;
   logic             o_req;
   logic [4:0]       o_port;
   logic             i_grant;
   logic [WIDTH-1:0] o_data;
   logic             o_valid;
   logic             i_ready;
`ifdef NOC_PKT_COUNT_EN
   logic [15:0]      o_pkt_count;
`endif

   input_port_ctrl #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .LOCAL_X(4'd1), .LOCAL_Y(4'd1)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_head(i_head), .i_counter(i_counter),
      .o_pull(o_pull), .o_req(o_req), .o_port(o_port), .i_grant(i_grant),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready)
`ifdef NOC_PKT_COUNT_EN
      , .o_pkt_count(o_pkt_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   // FIFO contents and flits still waiting upstream of it
   logic [15:0] fifo[$];
   logic [15:0] src[$];

   // Packet-level reference model
   bit         m_req, m_send;
   logic [4:0] m_port;
   int         m_sent, m_total, m_pkts;

   // Stimulus policy
   int ready_mode, grant_delay_cfg, gwait, push_pct, hold_push;
   bit grant_drop_en, rdy_phase;

   // Observations from the DUT side
   int cyc, obs_x, obs_first, obs_last, stall, req_wait, nrdy_pull;
   logic [4:0] seen_port;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] route_of(input logic [15:0] h);
      int dx = int'(h[7:4]);
      int dy = int'(h[3:0]);
      if (dx > LX) return 5'b00001;
      if (dx < LX) return 5'b00010;
      if (dy > LY) return 5'b00100;
      if (dy < LY) return 5'b01000;
      return 5'b10000;
   endfunction

   task automatic model_reset();
      m_req = 0; m_send = 0; m_port = '0; m_sent = 0; m_total = -1; m_pkts = 0;
   endtask

   task automatic add_pkt(input logic [15:0] hdr, input int size);
      src.push_back(hdr);
      src.push_back(16'(size));
      for (int i = 0; i < size; i++) src.push_back(16'($urandom));
   endtask

   task automatic preload(input int n);
      for (int i = 0; i < n; i++) fifo.push_back(src.pop_front());
   endtask

   task automatic begin_scn();
      obs_x = 0; obs_first = -1; obs_last = -1; stall = 0; req_wait = 0; seen_port = '0;
   endtask

   // One clock cycle: drive, compare against the model, then advance model and FIFO for the next edge
   task automatic step(input bit rst);
      logic exp_valid, exp_pull;
      @(negedge i_clk);
      i_rst     = rst;
      i_counter = CW'(fifo.size());
      i_head    = (fifo.size() != 0) ? fifo[0] : 16'($urandom);
      case (ready_mode)
         0: i_ready = 1'b1;
         1: begin i_ready = rdy_phase; rdy_phase = !rdy_phase; end
         default: i_ready = 1'($urandom_range(0, 1));
      endcase
      if (!m_req) begin
         i_grant = 1'b0;
         gwait   = grant_delay_cfg;
      end else if (!m_send) begin
         if (gwait == 0) i_grant = 1'b1;
         else begin i_grant = 1'b0; gwait--; end
      end else begin
         i_grant = grant_drop_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      exp_valid = m_send && (fifo.size() != 0);
      exp_pull  = exp_valid && i_ready && i_grant;
      chk("req", 32'(o_req), 32'(m_req));
      chk("port", 32'(o_port), 32'(m_port));
      chk("valid", 32'(o_valid), 32'(exp_valid));
      chk("pull", 32'(o_pull), 32'(exp_pull));
      chk("data", 32'(o_data), 32'(i_head));
`ifdef NOC_PKT_COUNT_EN
      chk("pkt_count", 32'(o_pkt_count), 32'(m_pkts & 'hFFFF));
`endif
      if (o_pull === 1'b1) begin
         obs_x++;
         if (obs_first < 0) obs_first = cyc;
         obs_last = cyc;
         if (i_ready !== 1'b1) nrdy_pull++;
      end
      if (o_req === 1'b1 && o_valid === 1'b0 && obs_x > 0) stall++;
      if (o_req === 1'b1 && obs_x == 0 && o_pull !== 1'b1) req_wait++;
      if (o_req === 1'b1) seen_port = o_port;
      cyc++;
      if (!rst) begin
         model_reset();
         fifo.delete();
         src.delete();
      end else begin
         if (!m_req) begin
            if (fifo.size() != 0) begin m_req = 1; m_port = route_of(i_head); end
         end else if (!m_send) begin
            if (i_grant) m_send = 1;
         end else if (exp_pull) begin
            m_sent++;
            if (m_sent == 2) m_total = 2 + int'(i_head);
            if (m_sent == m_total) begin
               m_req = 0; m_send = 0; m_port = '0; m_sent = 0; m_total = -1; m_pkts++;
            end
         end
         if (exp_pull) void'(fifo.pop_front());
         if (hold_push > 0) hold_push--;
         else if (src.size() != 0 && fifo.size() < DEPTH && $urandom_range(0, 99) < push_pct)
            fifo.push_back(src.pop_front());
      end
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n = 0;
      while (!(!m_req && fifo.size() == 0 && src.size() == 0) && n < budget) begin
         step(1'b1);
         n++;
      end
      chk(tag, 32'(!m_req && fifo.size() == 0 && src.size() == 0), 32'd1);
      step(1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int n;
      i_rst = 1'b0; i_head = '0; i_counter = '0; i_grant = 1'b0; i_ready = 1'b0;
      model_reset();
      ready_mode = 0; grant_delay_cfg = 0; gwait = 0; push_pct = 100; hold_push = 0;
      grant_drop_en = 0; rdy_phase = 1; cyc = 0; nrdy_pull = 0;
      repeat (2) @(posedge i_clk);

      // Reset state
      step(1'b0);
      step(1'b0);

      // East, size 2, back-to-back streaming
      begin_scn();
      add_pkt(16'h0031, 2); preload(4);
      run_idle("s1_done", 40);
      chk("s1_port", 32'(seen_port), 32'h01);
      chk("s1_xfers", 32'(obs_x), 32'd4);
      chk("s1_consecutive", 32'(obs_last - obs_first), 32'd3);
      chk("s1_req_wait", 32'(req_wait), 32'd1);

      // Local, zero size: header and size only
      begin_scn();
      add_pkt(16'h0011, 0); preload(2);
      run_idle("s2_done", 40);
      chk("s2_port", 32'(seen_port), 32'h10);
      chk("s2_xfers", 32'(obs_x), 32'd2);

      // North, size 3, ready toggling
      begin_scn();
      ready_mode = 1;
      add_pkt(16'h0013, 3); preload(5);
      run_idle("s3_done", 60);
      chk("s3_port", 32'(seen_port), 32'h04);
      chk("s3_xfers", 32'(obs_x), 32'd5);
      chk("s3_pull_not_ready", 32'(nrdy_pull), 32'd0);
      ready_mode = 0;

      // South, grant delayed 5 cycles
      begin_scn();
      grant_delay_cfg = 5;
      add_pkt(16'h0010, 1); preload(3);
      run_idle("s4_done", 60);
      chk("s4_port", 32'(seen_port), 32'h08);
      chk("s4_req_wait", 32'(req_wait), 32'd6);
      chk("s4_xfers", 32'(obs_x), 32'd3);
      grant_delay_cfg = 0;

      // West, size 4, FIFO runs dry after 3 flits and refills 3 cycles later
      begin_scn();
      add_pkt(16'h0001, 4); preload(3);
      hold_push = 7;
      run_idle("s5_done", 60);
      chk("s5_port", 32'(seen_port), 32'h02);
      chk("s5_stall", 32'(stall), 32'd3);
      chk("s5_xfers", 32'(obs_x), 32'd6);

      // Reset mid-payload
      begin_scn();
      add_pkt(16'h0031, 4); preload(6);
      n = 0;
      while (obs_x < 3 && n < 20) begin step(1'b1); n++; end
      chk("s6_reached_payload", 32'(obs_x >= 3), 32'd1);
      step(1'b0);
      step(1'b1);
      chk("s6_rst_req", 32'(o_req), 32'd0);
      chk("s6_rst_valid", 32'(o_valid), 32'd0);
`ifdef NOC_PKT_COUNT_EN
      chk("s6_rst_count", 32'(o_pkt_count), 32'd0);
`endif
      begin_scn();
      add_pkt(16'h0031, 1); preload(3);
      run_idle("s6_pkt1", 40);
      add_pkt(16'h0013, 2); preload(4);
      run_idle("s6_pkt2", 40);
      chk("s6_two_pkt_xfers", 32'(obs_x), 32'd7);
`ifdef NOC_PKT_COUNT_EN
      chk("s6_pkt_count", 32'(o_pkt_count), 32'd2);
`endif

      // Randomized traffic: random headers, sizes, ready, grant delay and grant drops
      ready_mode = 2; grant_drop_en = 1; push_pct = 60;
      for (int b = 0; b < 10; b++) begin
         grant_delay_cfg = $urandom_range(0, 3);
         for (int p = 0; p < 3; p++) add_pkt(16'($urandom), $urandom_range(0, 6));
         run_idle("rand_done", 1500);
      end
      chk("rand_pull_not_ready", 32'(nrdy_pull), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_port_ctrl.md
# input_port_ctrl

Per-port packet controller sitting directly downstream of a router input FIFO. It watches the FIFO head and occupancy, decodes the XY route from the header flit, and requests the chosen output port from the crossbar arbiter. Once granted, it streams the whole packet (header, size flit, payload) to the crossbar with a valid/ready handshake and drives the FIFO pull. Wormhole switching: the grant is held until the last payload flit has been transferred.

## Interface
- WIDTH, `TAM_FLIT: flit width; must be even and ≥ 8.
- DEPTH, `TAM_BUFFER: depth of the upstream FIFO; sets the counter width.
- LOCAL_X, 0: router X coordinate, WIDTH/4 bits.
- LOCAL_Y, 0: router Y coordinate, WIDTH/4 bits.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-low reset.
- i_head  in  WIDTH  FIFO head flit.
- i_counter  in  $clog2(DEPTH)+1  FIFO occupancy.
- o_pull  out  1  FIFO pop; combinational.
- o_req  out  1  arbiter request; registered.
- o_port  out  5  one-hot requested port: bit0 EAST, bit1 WEST, bit2 NORTH, bit3 SOUTH, bit4 LOCAL; registered.
- i_grant  in  1  arbiter grant for o_port; level, held while o_req is high.
- o_data  out  WIDTH  flit to crossbar, equal to i_head.
- o_valid  out  1  o_data valid; combinational.
- i_ready  in  1  crossbar/downstream can accept a flit.
- o_pkt_count  out  16  packets forwarded; present only with NOC_PKT_COUNT_EN.

## Operation
- FSM states: IDLE, REQ, SEND.
- **IDLE**
  - o_req=0, o_valid=0, o_pull=0.
  - If i_counter≠0, register the route from i_head and go to REQ.
- **Route decode**
  - dx = i_head[WIDTH/2-1:WIDTH/4], dy = i_head[WIDTH/4-1:0], compared unsigned.
  - dx>LOCAL_X → EAST; dx<LOCAL_X → WEST; else dy>LOCAL_Y → NORTH; dy<LOCAL_Y → SOUTH; else LOCAL.
  - Upper header bits are ignored.
- **REQ**
  - o_req=1, o_port stable.
  - On i_grant=1, go to SEND.
- **SEND**
  - o_req=1.
  - o_valid = (i_counter≠0).
  - o_pull = o_valid & i_ready & i_grant.
  - A transfer is any cycle with o_pull=1.
  - A flit-index register selects the role of each transfer: header, then size, then payload.
  - On the size transfer, load a WIDTH-bit remaining counter with the size flit (unsigned).
  - Each payload transfer decrements the remaining counter.
- **Last flit**
  - The last flit is the size flit when size=0, otherwise the payload transfer with remaining=1.
  - On the last-flit transfer, go to IDLE; o_req and o_port clear on the same edge.
- An empty FIFO mid-packet stalls the transfer (o_valid=0) without releasing the request.
- If i_grant drops while in SEND, no transfers occur; state is held.

## Timing
- Reset values: o_req=0, o_port=0, o_pull=0, o_valid=0, o_pkt_count=0, state IDLE, counters 0.
- Reset mid-packet: abandon the packet and return to IDLE the next edge; no partial flush. The FIFO is reset by the same i_rst.
- Latency: FIFO non-empty at cycle t → o_req=1 at t+1 → earliest grant at t+1 → first transfer at t+2.
- Throughput in SEND: one flit per cycle while i_counter≠0 and i_ready=1.
- i_counter reflects a pull one cycle later. A back-to-back transfer therefore relies on i_counter≥2, or on a simultaneous FIFO push.
- After the last flit: IDLE at the next cycle; a following packet's o_req rises one cycle after that (minimum 2-cycle gap between packets).
- Size arithmetic is unsigned WIDTH-bit; max payload is 2^WIDTH−1 flits, with no wrap.

## Configuration
- NOC_PKT_COUNT_EN defined: o_pkt_count increments by 1 on each last-flit transfer and wraps 0xFFFF→0. It is cleared by reset.
- NOC_PKT_COUNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- LOCAL=(1,1), WIDTH=16, header 0x0031, size 2, i_ready=1, immediate grant → o_port=5'b00001, 4 transfers in 4 consecutive cycles, o_req falls after the 4th.
- Header 0x0011 at (1,1), size 0 → o_port=5'b10000, exactly 2 transfers, then IDLE.
- Header 0x0013 at (1,1), size 3, i_ready toggling 1/0 → o_port NORTH, 5 transfers, o_pull never high while i_ready=0.
- Grant delayed 5 cycles → o_req held high and o_pull=0 for all 5 cycles; then normal streaming.
- Size 4 with FIFO draining after 3 flits, refilled 3 cycles later → o_valid=0 during the gap, o_req held, remaining payload completes.
- i_rst=0 mid-payload → next cycle o_req=0, o_valid=0; with NOC_PKT_COUNT_EN, o_pkt_count=0. Two full packets afterwards → o_pkt_count=2.
